// File: rtl/time_entry_decoder_if.sv
// Digit-entry and load handshake bundle between keypad source and time decoder.
// master drives digits/cancel/load_ready; slave (decoder) drives status and the decoded time.
interface time_entry_decoder_if;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        digit_ready;
  logic        cancel;
  logic [2:0]  digit_ptr;
  logic [23:0] digits;
  logic [7:0]  hrs;
  logic [7:0]  min;
  logic [7:0]  sec;
  logic        load_valid;
  logic        load_ready;
  logic        err;

  modport master (
    output digit_in, digit_valid, cancel, load_ready,
    input  digit_ready, digit_ptr, digits, hrs, min, sec, load_valid, err
  );

  modport slave (
    input  digit_in, digit_valid, cancel, load_ready,
    output digit_ready, digit_ptr, digits, hrs, min, sec, load_valid, err
  );
endinterface

// File: rtl/time_entry_decoder.sv
// Collects six BCD digits HH:MM:SS, range-checks them, then offers the binary time for load.
// Latency: 6th digit accepted at edge N -> load_valid after edge N+2; digits accepted only in ENTRY.
module time_entry_decoder #(
  parameter logic [7:0] HR_MAX = 8'd23,
  parameter logic [7:0] MS_MAX = 8'd59
) (
  input  logic                clk,
  input  logic                reset,
  time_entry_decoder_if.slave bus
);

  typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_LOAD} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_phase, w_phase_nxt;
  logic [2:0]  r_ptr, w_ptr_nxt;
  logic [23:0] r_digits, w_digits_nxt;
  logic [7:0]  r_hrs, w_hrs_nxt;
  logic [7:0]  r_min, w_min_nxt;
  logic [7:0]  r_sec, w_sec_nxt;
  logic        r_err, w_err_nxt;
  logic        w_reject;

  function automatic logic [7:0] bcd2bin(input logic [3:0] msb, input logic [3:0] lsb);
    return 8'(msb) * 8'd10 + 8'(lsb);
  endfunction

  assign w_reject = (bus.digit_in > 4'd9) ||
                    ((r_ptr == 3'd0) && (bus.digit_in > 4'd2)) ||
                    (((r_ptr == 3'd2) || (r_ptr == 3'd4)) && (bus.digit_in > 4'd5));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_ENTRY;
      r_phase  <= 1'b0;
      r_ptr    <= '0;
      r_digits <= '0;
      r_hrs    <= '0;
      r_min    <= '0;
      r_sec    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_ptr    <= w_ptr_nxt;
      r_digits <= w_digits_nxt;
      r_hrs    <= w_hrs_nxt;
      r_min    <= w_min_nxt;
      r_sec    <= w_sec_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_ptr_nxt    = r_ptr;
    w_digits_nxt = r_digits;
    w_hrs_nxt    = r_hrs;
    w_min_nxt    = r_min;
    w_sec_nxt    = r_sec;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      ST_ENTRY: begin
        if (bus.cancel) begin
          w_ptr_nxt    = '0;
          w_digits_nxt = '0;
        end else if (bus.digit_valid) begin
          if (w_reject) begin
            w_err_nxt = 1'b1;
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (r_ptr == 3'(i)) w_digits_nxt[23-4*i -: 4] = bus.digit_in;
            end
            w_ptr_nxt = r_ptr + 3'd1;
            if (r_ptr == 3'd5) begin
              w_state_nxt = ST_CHECK;
              w_phase_nxt = 1'b0;
            end
          end
        end
      end
      // CHECK is two cycles: register the binary fields, then compare the registered values.
      ST_CHECK: begin
        if (bus.cancel) begin
          w_state_nxt  = ST_ENTRY;
          w_phase_nxt  = 1'b0;
          w_ptr_nxt    = '0;
          w_digits_nxt = '0;
        end else if (!r_phase) begin
          w_hrs_nxt   = bcd2bin(r_digits[23:20], r_digits[19:16]);
          w_min_nxt   = bcd2bin(r_digits[15:12], r_digits[11:8]);
          w_sec_nxt   = bcd2bin(r_digits[7:4],   r_digits[3:0]);
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if ((r_hrs > HR_MAX) || (r_min > MS_MAX) || (r_sec > MS_MAX)) begin
            w_err_nxt    = 1'b1;
            w_state_nxt  = ST_ENTRY;
            w_ptr_nxt    = '0;
            w_digits_nxt = '0;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (bus.load_ready || bus.cancel) begin
          w_state_nxt  = ST_ENTRY;
          w_ptr_nxt    = '0;
          w_digits_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
      end
    endcase
  end

  assign bus.digit_ready = (r_state == ST_ENTRY);
  assign bus.load_valid  = (r_state == ST_LOAD);
  assign bus.digit_ptr   = r_ptr;
  assign bus.digits      = r_digits;
  assign bus.hrs         = r_hrs;
  assign bus.min         = r_min;
  assign bus.sec         = r_sec;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_time_entry_decoder.sv
// Directed scenarios plus a randomized run against a digit-queue reference model.
module tb_time_entry_decoder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  time_entry_decoder_if bus();
  time_entry_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.cancel      = 1'b0;
    bus.load_ready  = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic send_digit(input int d);
    bus.digit_valid = 1'b1;
    bus.digit_in    = 4'(d);
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic send_time(input int a, input int b, input int c, input int d, input int e, input int f);
    send_digit(a); send_digit(b); send_digit(c); send_digit(d); send_digit(e); send_digit(f);
  endtask

  function automatic bit legal_digit(input int pos, input int d);
    if (d > 9) return 1'b0;
    if (pos == 0 && d > 2) return 1'b0;
    if ((pos == 2 || pos == 4) && d > 5) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [23:0] pack_digits(input int q[$]);
    logic [23:0] r;
    r = '0;
    foreach (q[i]) r[23-4*i -: 4] = 4'(q[i]);
    return r;
  endfunction

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    #2;
    checks++;
    if ({bus.digit_ptr, bus.digits} !== {3'd0, 24'd0}) begin
      errors++; $display("FAIL reset_ptr_digits got %0h/%06h want 0/000000", bus.digit_ptr, bus.digits);
    end
    checks++;
    if ({bus.hrs, bus.min, bus.sec} !== 24'd0) begin
      errors++; $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", bus.hrs, bus.min, bus.sec);
    end
    checks++;
    if ({bus.load_valid, bus.err, bus.digit_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_flags got lv=%b err=%b rdy=%b want 0 0 1", bus.load_valid, bus.err, bus.digit_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_basic;
    bus.digit_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.digit_in = 4'(i);
      tick();
      checks++;
      if (bus.digit_ptr !== 3'(i)) begin
        errors++; $display("FAIL basic_ptr got %0d want %0d", bus.digit_ptr, i);
      end
    end
    bus.digit_valid = 1'b0;
    checks++;
    if ({bus.load_valid, bus.digit_ready} !== 2'b00) begin
      errors++; $display("FAIL basic_after_n got lv=%b rdy=%b want 0 0", bus.load_valid, bus.digit_ready);
    end
    tick();
    checks++;
    if (bus.load_valid !== 1'b0) begin
      errors++; $display("FAIL basic_n1 got lv=%b want 0", bus.load_valid);
    end
    tick();
    checks++;
    if (bus.load_valid !== 1'b1) begin
      errors++; $display("FAIL basic_n2 got lv=%b want 1", bus.load_valid);
    end
    checks++;
    if ({bus.hrs, bus.min, bus.sec, bus.digits} !== {8'd12, 8'd34, 8'd56, 24'h123456}) begin
      errors++; $display("FAIL basic_time got %0d:%0d:%0d %06h want 12:34:56 123456", bus.hrs, bus.min, bus.sec, bus.digits);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.load_valid, bus.hrs, bus.min, bus.sec, bus.digits} !== {1'b1, 8'd12, 8'd34, 8'd56, 24'h123456}) begin
        errors++; $display("FAIL hold_stable cyc %0d got lv=%b %0d:%0d:%0d %06h", i, bus.load_valid, bus.hrs, bus.min, bus.sec, bus.digits);
      end
    end
    bus.load_ready = 1'b1;
    tick();
    bus.load_ready = 1'b0;
    checks++;
    if ({bus.load_valid, bus.digit_ready, bus.digit_ptr, bus.digits} !== {1'b0, 1'b1, 3'd0, 24'd0}) begin
      errors++; $display("FAIL load_done got lv=%b rdy=%b ptr=%0d dig=%06h want 0 1 0 0", bus.load_valid, bus.digit_ready, bus.digit_ptr, bus.digits);
    end
    tick();
    checks++;
    if ({bus.load_valid, bus.hrs} !== {1'b0, 8'd12}) begin
      errors++; $display("FAIL after_load got lv=%b hrs=%0d want 0 12", bus.load_valid, bus.hrs);
    end
  endtask

  task automatic test_reject;
    send_digit(3);
    checks++;
    if ({bus.err, bus.digit_ptr} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rej_ptr0 got err=%b ptr=%0d want 1 0", bus.err, bus.digit_ptr);
    end
    send_digit(1);
    send_digit(12);
    checks++;
    if ({bus.err, bus.digit_ptr, bus.digits} !== {1'b1, 3'd1, 24'h100000}) begin
      errors++; $display("FAIL rej_gt9 got err=%b ptr=%0d dig=%06h want 1 1 100000", bus.err, bus.digit_ptr, bus.digits);
    end
    send_digit(2);
    send_digit(6);
    checks++;
    if ({bus.err, bus.digit_ptr, bus.digits} !== {1'b1, 3'd2, 24'h120000}) begin
      errors++; $display("FAIL rej_ptr2 got err=%b ptr=%0d dig=%06h want 1 2 120000", bus.err, bus.digit_ptr, bus.digits);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL err_one_cycle got %b want 0", bus.err);
    end
    send_digit(3);
    checks++;
    if ({bus.err, bus.digit_ptr, bus.digits} !== {1'b0, 3'd3, 24'h123000}) begin
      errors++; $display("FAIL accept_after_rej got err=%b ptr=%0d dig=%06h want 0 3 123000", bus.err, bus.digit_ptr, bus.digits);
    end
    bus.cancel = 1'b1;
    send_digit(4);
    bus.cancel = 1'b0;
    checks++;
    if ({bus.err, bus.digit_ptr, bus.digits} !== {1'b0, 3'd0, 24'd0}) begin
      errors++; $display("FAIL cancel_wins got err=%b ptr=%0d dig=%06h want 0 0 0", bus.err, bus.digit_ptr, bus.digits);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL cancel_no_err got %b want 0", bus.err);
    end
  endtask

  task automatic test_range;
    bit seen_lv;
    send_time(2, 4, 0, 0, 0, 0);
    tick();
    checks++;
    if ({bus.err, bus.digit_ptr} !== {1'b0, 3'd6}) begin
      errors++; $display("FAIL range_n1 got err=%b ptr=%0d want 0 6", bus.err, bus.digit_ptr);
    end
    tick();
    checks++;
    if ({bus.err, bus.load_valid, bus.digit_ptr, bus.digits, bus.digit_ready} !== {1'b1, 1'b0, 3'd0, 24'd0, 1'b1}) begin
      errors++; $display("FAIL range_reject got err=%b lv=%b ptr=%0d dig=%06h rdy=%b", bus.err, bus.load_valid, bus.digit_ptr, bus.digits, bus.digit_ready);
    end
    seen_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.load_valid) seen_lv = 1'b1;
    end
    checks++;
    if ({seen_lv, bus.err} !== 2'b00) begin
      errors++; $display("FAIL range_no_load got lv_seen=%b err=%b want 0 0", seen_lv, bus.err);
    end
    send_time(2, 3, 5, 9, 5, 9);
    tick();
    tick();
    checks++;
    if ({bus.load_valid, bus.hrs, bus.min, bus.sec} !== {1'b1, 8'd23, 8'd59, 8'd59}) begin
      errors++; $display("FAIL range_max got lv=%b %0d:%0d:%0d want 1 23:59:59", bus.load_valid, bus.hrs, bus.min, bus.sec);
    end
    bus.cancel     = 1'b1;
    bus.load_ready = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({bus.load_valid, bus.digit_ptr, bus.digits, bus.err, bus.hrs} !== {1'b0, 3'd0, 24'd0, 1'b0, 8'd23}) begin
      errors++; $display("FAIL cancel_with_ready got lv=%b ptr=%0d dig=%06h err=%b hrs=%0d", bus.load_valid, bus.digit_ptr, bus.digits, bus.err, bus.hrs);
    end
  endtask

  task automatic test_cancel_paths;
    send_time(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    send_digit(5);
    checks++;
    if ({bus.load_valid, bus.err, bus.digit_ptr, bus.digits} !== {1'b1, 1'b0, 3'd6, 24'h000001}) begin
      errors++; $display("FAIL digit_in_load got lv=%b err=%b ptr=%0d dig=%06h", bus.load_valid, bus.err, bus.digit_ptr, bus.digits);
    end
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    checks++;
    if ({bus.load_valid, bus.err, bus.digit_ptr, bus.digits} !== {1'b0, 1'b0, 3'd0, 24'd0}) begin
      errors++; $display("FAIL cancel_load got lv=%b err=%b ptr=%0d dig=%06h want 0 0 0 0", bus.load_valid, bus.err, bus.digit_ptr, bus.digits);
    end
    send_time(1, 1, 1, 1, 1, 1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.load_valid, bus.err, bus.digit_ptr, bus.digit_ready} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL cancel_check got lv=%b err=%b ptr=%0d rdy=%b want 0 0 0 1", bus.load_valid, bus.err, bus.digit_ptr, bus.digit_ready);
    end
  endtask

  task automatic test_reset_mid_load;
    send_time(0, 9, 3, 0, 4, 5);
    tick();
    tick();
    checks++;
    if ({bus.load_valid, bus.hrs, bus.min, bus.sec} !== {1'b1, 8'd9, 8'd30, 8'd45}) begin
      errors++; $display("FAIL pre_reset_load got lv=%b %0d:%0d:%0d want 1 9:30:45", bus.load_valid, bus.hrs, bus.min, bus.sec);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.load_valid, bus.err, bus.digit_ready, bus.digit_ptr, bus.digits, bus.hrs, bus.min, bus.sec} !== {1'b0, 1'b0, 1'b1, 3'd0, 24'd0, 24'd0}) begin
      errors++; $display("FAIL async_reset got lv=%b err=%b rdy=%b ptr=%0d dig=%06h %0d:%0d:%0d", bus.load_valid, bus.err, bus.digit_ready, bus.digit_ptr, bus.digits, bus.hrs, bus.min, bus.sec);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    checks++;
    if ({bus.load_valid, bus.digit_ready, bus.digit_ptr} !== {1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL post_reset got lv=%b rdy=%b ptr=%0d want 0 1 0", bus.load_valid, bus.digit_ready, bus.digit_ptr);
    end
  endtask

  task automatic test_random;
    int  q[$];
    int  chk_cycles;
    bit  loaded;
    bit  e_err;
    int  e_h, e_m, e_s;
    int  d;
    do_reset();
    chk_cycles = -1;
    loaded = 1'b0;
    e_h = 0; e_m = 0; e_s = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.digit_valid = ($urandom % 4) != 0;
      if ($urandom % 10 == 0)             d = $urandom_range(0, 15);
      else if (q.size() == 0)             d = $urandom_range(0, 2);
      else if (q.size() == 2 || q.size() == 4) d = $urandom_range(0, 5);
      else                                d = $urandom_range(0, 9);
      bus.digit_in   = 4'(d);
      bus.cancel     = ($urandom % 30) == 0;
      bus.load_ready = ($urandom % 3) == 0;

      e_err = 1'b0;
      if (loaded) begin
        if (bus.load_ready || bus.cancel) begin
          q.delete();
          loaded = 1'b0;
        end
      end else if (chk_cycles >= 0) begin
        if (bus.cancel) begin
          q.delete();
          chk_cycles = -1;
        end else if (chk_cycles == 0) begin
          e_h = q[0] * 10 + q[1];
          e_m = q[2] * 10 + q[3];
          e_s = q[4] * 10 + q[5];
          chk_cycles = 1;
        end else begin
          chk_cycles = -1;
          if (e_h > 23 || e_m > 59 || e_s > 59) begin
            e_err = 1'b1;
            q.delete();
          end else begin
            loaded = 1'b1;
          end
        end
      end else if (bus.cancel) begin
        q.delete();
      end else if (bus.digit_valid) begin
        if (legal_digit(q.size(), d)) begin
          q.push_back(d);
          if (q.size() == 6) chk_cycles = 0;
        end else begin
          e_err = 1'b1;
        end
      end

      tick();
      checks++;
      if ({bus.digit_ptr, bus.digits, bus.digit_ready} !== {3'(q.size()), pack_digits(q), q.size() < 6}) begin
        errors++; $display("FAIL rand_entry cyc %0d got ptr=%0d dig=%06h rdy=%b want ptr=%0d dig=%06h", cyc, bus.digit_ptr, bus.digits, bus.digit_ready, q.size(), pack_digits(q));
      end
      checks++;
      if ({bus.err, bus.load_valid} !== {e_err, loaded}) begin
        errors++; $display("FAIL rand_flags cyc %0d got err=%b lv=%b want err=%b lv=%b", cyc, bus.err, bus.load_valid, e_err, loaded);
      end
      checks++;
      if ({bus.hrs, bus.min, bus.sec} !== {8'(e_h), 8'(e_m), 8'(e_s)}) begin
        errors++; $display("FAIL rand_time cyc %0d got %0d:%0d:%0d want %0d:%0d:%0d", cyc, bus.hrs, bus.min, bus.sec, e_h, e_m, e_s);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_range();
    test_cancel_paths();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
